// File: rtl/router_sync.sv
// router_sync: destination latch, FIFO write steering and per-port read watchdog.
// Watchdog built only when ROUTER_SYNC_TIMEOUT_EN is defined; otherwise soft resets tie low.
module router_sync #(
    parameter int TIMEOUT = 30
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [2:0] data_in,
    input  logic       write_enb_reg,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    logic [1:0] int_addr;
    logic [2:0] vld;
    logic [2:0] soft_reset;
    logic       unused_data_bit;

    assign unused_data_bit = data_in[2];

    always_ff @(posedge clock) begin
        if (reset) begin
            int_addr <= 2'b11;
        end else if (detect_add) begin
            int_addr <= data_in[1:0];
        end
    end

    // Address 2'b11 is the idle "no destination" code.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        unique case (int_addr)
            2'b00: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'b01: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'b10: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld = ~{empty_2, empty_1, empty_0};

    assign vld_out_0 = vld[0];
    assign vld_out_1 = vld[1];
    assign vld_out_2 = vld[2];

`ifdef ROUTER_SYNC_TIMEOUT_EN
    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT - 1);

    logic [2:0] read_enb;

    assign read_enb = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar p = 0; p < 3; p++) begin : g_wdog
        logic [4:0] cnt;
        logic       pulse;

        always_ff @(posedge clock) begin
            if (reset) begin
                cnt   <= 5'd0;
                pulse <= 1'b0;
            end else if (!vld[p] || read_enb[p]) begin
                cnt   <= 5'd0;
                pulse <= 1'b0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= 5'd0;
                pulse <= 1'b1;
            end else begin
                cnt   <= cnt + 5'd1;
                pulse <= 1'b0;
            end
        end

        assign soft_reset[p] = pulse;
    end
`else
    logic [2:0] unused_read_enb;

    assign unused_read_enb = {read_enb_2, read_enb_1, read_enb_0};
    assign soft_reset      = 3'b000;
`endif

    assign soft_reset_0 = soft_reset[0];
    assign soft_reset_1 = soft_reset[1];
    assign soft_reset_2 = soft_reset[2];

endmodule

// File: tb/tb_router_sync.sv
// tb_router_sync: scoreboard bench for router_sync.
// Expected outputs come from an idle-run-length model queued per cycle.
module tb_router_sync;

    localparam int TMO = 30;
`ifdef ROUTER_SYNC_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] we;
        logic       full;
        logic [2:0] vld;
        logic [2:0] sr;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       detect_add;
    logic [2:0] data_in;
    logic       write_enb_reg;
    logic [2:0] empty;
    logic [2:0] full;
    logic [2:0] rd;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int total = 0;
    int bad = 0;

    exp_t exp_q[$];

    logic [1:0] m_addr;
    int         run[3];
    logic [2:0] m_sr;

    always #5 clock = ~clock;

    router_sync #(.TIMEOUT(TMO)) dut (
        .clock(clock),
        .reset(reset),
        .detect_add(detect_add),
        .data_in(data_in),
        .write_enb_reg(write_enb_reg),
        .empty_0(empty[0]),
        .empty_1(empty[1]),
        .empty_2(empty[2]),
        .full_0(full[0]),
        .full_1(full[1]),
        .full_2(full[2]),
        .read_enb_0(rd[0]),
        .read_enb_1(rd[1]),
        .read_enb_2(rd[2]),
        .write_enb(write_enb),
        .fifo_full(fifo_full),
        .vld_out_0(vld_out_0),
        .vld_out_1(vld_out_1),
        .vld_out_2(vld_out_2),
        .soft_reset_0(soft_reset_0),
        .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s @%0t: got=%0h want=%0h", tag, $time, got, want);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.we   = 3'b000;
        e.full = 1'b0;
        case (m_addr)
            2'd0: begin e.we = {2'b00, write_enb_reg};       e.full = full[0]; end
            2'd1: begin e.we = {1'b0, write_enb_reg, 1'b0};  e.full = full[1]; end
            2'd2: begin e.we = {write_enb_reg, 2'b00};       e.full = full[2]; end
            default: ;
        endcase
        e.vld = ~empty;
        e.sr  = m_sr;
        return e;
    endfunction

    task automatic model_edge();
        if (reset) begin
            m_addr = 2'b11;
            m_sr   = 3'b000;
            for (int p = 0; p < 3; p++) run[p] = 0;
        end else begin
            if (detect_add) m_addr = data_in[1:0];
            for (int p = 0; p < 3; p++) begin
                if (empty[p] || rd[p]) begin
                    run[p]  = 0;
                    m_sr[p] = 1'b0;
                end else begin
                    run[p]++;
                    m_sr[p] = WD_EN && (run[p] % TMO == 0);
                end
            end
        end
    endtask

    task automatic tick(input logic rst, input logic det, input logic [2:0] din,
                        input logic wer, input logic [2:0] emp,
                        input logic [2:0] ful, input logic [2:0] rde);
        exp_t e;
        reset         = rst;
        detect_add    = det;
        data_in       = din;
        write_enb_reg = wer;
        empty         = emp;
        full          = ful;
        rd            = rde;
        exp_q.push_back(model_out());
        @(negedge clock);
        e = exp_q.pop_front();
        chk("write_enb", {5'd0, write_enb}, {5'd0, e.we});
        chk("fifo_full", {7'd0, fifo_full}, {7'd0, e.full});
        chk("vld_out", {5'd0, vld_out_2, vld_out_1, vld_out_0}, {5'd0, e.vld});
        chk("soft_reset", {5'd0, soft_reset_2, soft_reset_1, soft_reset_0},
            {5'd0, e.sr});
        @(posedge clock);
        model_edge();
        #1;
    endtask

    int pulses;

    initial begin
        reset = 1'b1; detect_add = 1'b0; data_in = 3'b000;
        write_enb_reg = 1'b0; empty = 3'b111; full = 3'b000; rd = 3'b000;
        @(posedge clock);
        #1;
        m_addr = 2'b11;
        m_sr   = 3'b000;
        for (int p = 0; p < 3; p++) run[p] = 0;

        // reset state, vld follows empty during reset
        tick(1, 0, 3'b000, 0, 3'b111, 3'b000, 3'b000);
        tick(1, 1, 3'b001, 1, 3'b010, 3'b111, 3'b000);
        // no header yet
        tick(0, 0, 3'b000, 1, 3'b111, 3'b111, 3'b000);
        chk("no_hdr_we", {5'd0, write_enb}, 8'd0);
        // header 001 with write strobe: old address in this cycle
        tick(0, 1, 3'b001, 1, 3'b111, 3'b000, 3'b000);
        tick(0, 0, 3'b000, 1, 3'b111, 3'b010, 3'b000);
        tick(0, 0, 3'b000, 0, 3'b111, 3'b101, 3'b000);
        tick(0, 1, 3'b100, 1, 3'b111, 3'b001, 3'b000);
        tick(0, 0, 3'b000, 1, 3'b111, 3'b001, 3'b000);
        tick(0, 1, 3'b110, 1, 3'b111, 3'b100, 3'b000);
        tick(0, 0, 3'b000, 1, 3'b111, 3'b100, 3'b000);
        // address 11: nothing enabled, no full
        tick(0, 1, 3'b011, 1, 3'b111, 3'b111, 3'b000);
        tick(0, 0, 3'b000, 1, 3'b111, 3'b111, 3'b000);

        // port 2 valid and unread: pulses at 31 and 61
        pulses = 0;
        for (int c = 0; c < 65; c++) begin
            tick(0, 0, 3'b000, 0, 3'b011, 3'b000, 3'b000);
            if (soft_reset_2) pulses++;
        end
        chk("p2_pulses", 8'(pulses), WD_EN ? 8'd2 : 8'd0);

        // read at cycle 29 cancels the pending timeout
        tick(1, 0, 3'b000, 0, 3'b111, 3'b000, 3'b000);
        for (int c = 0; c < 65; c++)
            tick(0, 0, 3'b000, 0, 3'b011, 3'b000, (c == 28) ? 3'b100 : 3'b000);

        // reset at count 20
        tick(1, 0, 3'b000, 0, 3'b111, 3'b000, 3'b000);
        for (int c = 0; c < 20; c++)
            tick(0, 0, 3'b010, 1, 3'b011, 3'b000, 3'b000);
        tick(1, 1, 3'b000, 1, 3'b011, 3'b111, 3'b000);
        for (int c = 0; c < 34; c++)
            tick(0, 0, 3'b000, 1, 3'b011, 3'b111, 3'b000);

        // all three ports fire together
        tick(1, 0, 3'b000, 0, 3'b111, 3'b000, 3'b000);
        for (int c = 0; c < 33; c++)
            tick(0, 0, 3'b000, 0, 3'b000, 3'b000, 3'b000);

        // random traffic with rare reads
        for (int c = 0; c < 300; c++) begin
            logic [2:0] emp, rde;
            for (int p = 0; p < 3; p++) begin
                emp[p] = ($urandom_range(0, 11) == 0);
                rde[p] = ($urandom_range(0, 39) == 0);
            end
            tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
                 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 emp, 3'($urandom_range(0, 7)), rde);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/router_sync.md
# router_sync

Port-select and watchdog stage sitting directly upstream of the three output FIFOs of the router. It latches the destination address from each packet header and steers the single input-side write strobe to exactly one FIFO. It reports that FIFO's full flag back to the input controller and drives per-port valid outputs from the FIFO empty flags. A per-port timeout watchdog issues a one-cycle soft reset to any FIFO whose pending data has not been read for TIMEOUT consecutive cycles.

## Interface
- TIMEOUT, 30, consecutive valid-but-unread cycles before a port's soft reset fires; legal range 2..31.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- detect_add  in  1  header cycle strobe from the input controller; address is captured on this edge.
- data_in  in  3  input data bus; bits [1:0] carry the destination address during a header cycle; bit 2 is ignored.
- write_enb_reg  in  1  write request from the input controller for the currently addressed port.
- empty_0, empty_1, empty_2  in  1 each  FIFO empty flags.
- full_0, full_1, full_2  in  1 each  FIFO full flags.
- read_enb_0, read_enb_1, read_enb_2  in  1 each  downstream read strobes per port.
- write_enb  out  3  one-hot FIFO write enables; bit i drives FIFO i.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out_0, vld_out_1, vld_out_2  out  1 each  port has data (= ~empty_i).
- soft_reset_0, soft_reset_1, soft_reset_2  out  1 each  registered one-cycle timeout pulses to FIFO i.

## Operation
- Address register int_addr[1:0]:
  - Reset value 2'b11, meaning no destination.
  - On an edge with detect_add=1, loads data_in[1:0]; otherwise holds.
- write_enb is combinational from the registered int_addr:
  - equals 1<<int_addr when write_enb_reg=1 and int_addr<3;
  - otherwise 3'b000.
  - Address 2'b11 never enables any FIFO.
- fifo_full is combinational: full_<int_addr> for int_addr<3, else 0.
- vld_out_i = ~empty_i, combinational. Value during reset follows empty_i.
- Watchdog, one independent instance per port i:
  - 5-bit counter cnt_i and a registered soft_reset_i; both reset to 0.
  - Any edge with vld_out_i=0 or read_enb_i=1: cnt_i←0, soft_reset_i←0.
  - Edge with vld_out_i=1 and read_enb_i=0, cnt_i<TIMEOUT-1: cnt_i←cnt_i+1, soft_reset_i←0.
  - Edge with vld_out_i=1 and read_enb_i=0, cnt_i==TIMEOUT-1: cnt_i←0, soft_reset_i←1.
  - Result: soft_reset_i is a single-cycle pulse. If the port stays valid and unread, the next pulse follows TIMEOUT cycles later.
- Ports never interact; all three watchdogs may fire in the same cycle.

## Timing
- Address capture: 1-cycle latency. Header on edge N steers write_enb from cycle N+1 onward.
- detect_add and write_enb_reg high together: write_enb in that cycle uses the previous int_addr.
- write_enb, fifo_full and vld_out have zero latency from their inputs.
- soft_reset_i is high during the cycle after the TIMEOUT-th consecutive idle edge.
- A read_enb_i on any edge before that edge cancels the pending timeout.
- Reset asserted mid-operation: on that edge int_addr←2'b11 and all counters and soft_resets clear. Reset overrides detect_add.
- Counter arithmetic never wraps; its maximum value is TIMEOUT-1.

## Configuration
- ROUTER_SYNC_TIMEOUT_EN defined: the watchdog logic is built as described above.
- ROUTER_SYNC_TIMEOUT_EN undefined:
  - counters are not instantiated;
  - soft_reset_0..2 are tied to constant 0;
  - all other behaviour is unchanged.

## Test plan
- Reset, then write_enb_reg=1 with no header → write_enb=3'b000, fifo_full=0, all soft_reset outputs 0.
- Header with detect_add=1 and data_in=3'b001, then write_enb_reg=1 with full_1=1 → next cycle write_enb=3'b010 and fifo_full=1. On the header cycle itself write_enb reflects the old address.
- Header with data_in[1:0]=2'b11 → write_enb=3'b000 and fifo_full=0 regardless of the full inputs.
- empty_2=0, read_enb_2=0 held (TIMEOUT=30) → soft_reset_2 is one cycle high in cycle 31 and pulses again 30 cycles later.
- Same as the previous scenario but read_enb_2=1 at cycle 29 → no pulse; the count restarts and the next pulse comes 30 idle cycles after the read.
- Reset asserted at count 20 → counter clears, int_addr=2'b11, and no soft_reset pulse until 30 further idle cycles. Build without ROUTER_SYNC_TIMEOUT_EN → soft_reset outputs are never asserted.
